// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock timekeeping slice.
//   mode_t    : 2-bit operating mode (RUN / SET_HR / SET_MIN, 3 is illegal)
//   SEC_MAX   : last BCD seconds value before wrap
//   MIN_MAX   : last BCD minutes value before wrap
//   bcd_inc() : 2-digit BCD increment with wrap at a BCD limit, plus carry
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_t;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;

  typedef struct packed {
    logic       carry;
    logic [7:0] val;
  } bcd_inc_t;

  // Increment a two-digit BCD value; at the limit it wraps to 00 and
  // raises carry. Units 9 rolls to 0 with tens+1, no binary conversion.
  function automatic bcd_inc_t bcd_inc(input logic [7:0] val, input logic [7:0] lim);
    bcd_inc_t r;
    r.carry = 1'b0;
    if (val == lim) begin
      r.val   = '0;
      r.carry = 1'b1;
    end else if (val[3:0] == 4'd9) begin
      r.val = {val[7:4] + 4'd1, 4'd0};
    end else begin
      r.val = {val[7:4], val[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, 1KHz-sampled debounce
// counter and rising-edge press detector.
//   CP        : system clock
//   _CR       : asynchronous active-low reset
//   tick_1KHz : one-cycle sample strobe, once per millisecond
//   btn_raw   : raw active-high button, asynchronous to CP
//   press     : one-CP-cycle pulse, one cycle after the debounced level rises
module btn_debounce #(
  parameter int unsigned DEB_MS = 20
) (
  input  logic CP,
  input  logic _CR,
  input  logic tick_1KHz,
  input  logic btn_raw,
  output logic press
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_MS - 1);

  logic [1:0] sync_q;
  logic       level_q;
  logic       level_d_q;
  logic [7:0] cnt_q;

  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      sync_q    <= '0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      cnt_q     <= '0;
      press     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw};
      level_d_q <= level_q;
      press     <= level_q & ~level_d_q;
      if (tick_1KHz) begin
        // cnt_q counts consecutive samples that disagree with the accepted
        // level; any agreeing sample restarts the run.
        if (sync_q[1] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Timekeeping and time-set controller for the digital clock.
//   CP, _CR              : clock, asynchronous active-low reset
//   tick_1Hz, tick_1KHz  : single-cycle tick pulses from the divider
//   btn_mode, btn_adj    : raw push-buttons (active-high, asynchronous)
//   hour_bcd/min_bcd/sec_bcd : registered BCD time
//   mode                 : 0=RUN, 1=SET_HR, 2=SET_MIN
//   blank_hr, blank_min  : registered blink blanking for the field being set
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEB_MS   = 20,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       CP,
  input  logic       _CR,
  input  logic       tick_1Hz,
  input  logic       tick_1KHz,
  input  logic       btn_mode,
  input  logic       btn_adj,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min
);

  localparam logic [7:0] HOUR_LIM = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

  logic mode_press;
  logic adj_press;

  btn_debounce #(.DEB_MS(DEB_MS)) u_mode_db (
    .CP        (CP),
    ._CR       (_CR),
    .tick_1KHz (tick_1KHz),
    .btn_raw   (btn_mode),
    .press     (mode_press)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_adj_db (
    .CP        (CP),
    ._CR       (_CR),
    .tick_1KHz (tick_1KHz),
    .btn_raw   (btn_adj),
    .press     (adj_press)
  );

  mode_t      mode_q, mode_nxt;
  logic       phase_q, phase_nxt;
  logic [7:0] hour_q, hour_nxt;
  logic [7:0] min_q, min_nxt;
  logic [7:0] sec_q, sec_nxt;
  logic       blank_hr_q, blank_min_q;

  bcd_inc_t sec_inc, min_inc, hour_inc;
  logic     unused_hour_carry;

  assign sec_inc           = bcd_inc(sec_q, SEC_MAX);
  assign min_inc           = bcd_inc(min_q, MIN_MAX);
  assign hour_inc          = bcd_inc(hour_q, HOUR_LIM);
  assign unused_hour_carry = hour_inc.carry;

  always_comb begin
    mode_nxt  = mode_q;
    phase_nxt = phase_q;
    hour_nxt  = hour_q;
    min_nxt   = min_q;
    sec_nxt   = sec_q;
    case (mode_q)
      MODE_RUN: begin
        phase_nxt = 1'b0;
        if (tick_1Hz) begin
          sec_nxt = sec_inc.val;
          if (sec_inc.carry) begin
            min_nxt = min_inc.val;
            if (min_inc.carry) hour_nxt = hour_inc.val;
          end
        end
        if (mode_press) mode_nxt = MODE_SET_HR;
      end
      MODE_SET_HR: begin
        // A mode press swallows any coincident adjust press.
        if (mode_press) begin
          mode_nxt  = MODE_SET_MIN;
          phase_nxt = 1'b0;
        end else begin
          if (adj_press) hour_nxt = hour_inc.val;
          if (tick_1Hz) phase_nxt = ~phase_q;
        end
      end
      MODE_SET_MIN: begin
        if (mode_press) begin
          mode_nxt  = MODE_RUN;
          phase_nxt = 1'b0;
          sec_nxt   = '0;
        end else begin
          if (adj_press) min_nxt = min_inc.val;
          if (tick_1Hz) phase_nxt = ~phase_q;
        end
      end
      default: begin
        mode_nxt  = MODE_RUN;
        phase_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      mode_q      <= MODE_RUN;
      phase_q     <= 1'b0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      blank_hr_q  <= 1'b0;
      blank_min_q <= 1'b0;
    end else begin
      mode_q      <= mode_nxt;
      phase_q     <= phase_nxt;
      hour_q      <= hour_nxt;
      min_q       <= min_nxt;
      sec_q       <= sec_nxt;
      // Blanking is registered from next-state values so it always equals
      // (mode==field) & phase on the same cycle.
      blank_hr_q  <= (mode_nxt == MODE_SET_HR) & phase_nxt;
      blank_min_q <= (mode_nxt == MODE_SET_MIN) & phase_nxt;
    end
  end

  assign hour_bcd  = hour_q;
  assign min_bcd   = min_q;
  assign sec_bcd   = sec_q;
  assign mode      = mode_q;
  assign blank_hr  = blank_hr_q;
  assign blank_min = blank_min_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: a table of directed operations with
// hand-derived expected outputs, hand-written latency/reset sequences, and
// random operations checked against a seconds-of-day reference model.
module tb_clock_ctrl;

  localparam int unsigned DEB      = 4;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned DAY      = (HOUR_MAX + 1) * 3600;

  logic       CP = 1'b0;
  logic       cr_n = 1'b0;
  logic       tick_1Hz = 1'b0;
  logic       tick_1KHz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_adj = 1'b0;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic       blank_hr, blank_min;

  clock_ctrl #(.DEB_MS(DEB), .HOUR_MAX(HOUR_MAX)) dut (
    .CP        (CP),
    ._CR       (cr_n),
    .tick_1Hz  (tick_1Hz),
    .tick_1KHz (tick_1KHz),
    .btn_mode  (btn_mode),
    .btn_adj   (btn_adj),
    .hour_bcd  (hour_bcd),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .mode      (mode),
    .blank_hr  (blank_hr),
    .blank_min (blank_min)
  );

  always #5 CP = ~CP;

  int checks = 0;
  int errors = 0;

  typedef enum int {OP_TICK, OP_MODE, OP_ADJ, OP_BOTH, OP_MODE_T, OP_ADJ_T, OP_SHORT} op_e;

  typedef struct {
    op_e         op;
    int unsigned n;
    logic [7:0]  hr, mn, sc;
    logic [1:0]  md;
    logic        bh, bm;
  } vec_t;

  vec_t vecs[$];

  // Reference model: time of day in seconds, mode 0..2, blink phase.
  int unsigned m_t;
  int unsigned m_md;
  bit          m_ph;

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic m_reset();
    m_t = 0; m_md = 0; m_ph = 1'b0;
  endtask

  task automatic m_tick();
    if (m_md == 0) m_t = (m_t + 1) % DAY;
    else m_ph = ~m_ph;
  endtask

  task automatic m_mode();
    if (m_md == 2) m_t = m_t - (m_t % 60);
    m_md = (m_md + 1) % 3;
    m_ph = 1'b0;
  endtask

  task automatic m_adj();
    if (m_md == 1)
      m_t = ((m_t / 3600 + 1) % (HOUR_MAX + 1)) * 3600 + (m_t % 3600);
    else if (m_md == 2)
      m_t = (m_t / 3600) * 3600 + (((m_t / 60) % 60 + 1) % 60) * 60 + (m_t % 60);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] hr, input logic [7:0] mn,
                           input logic [7:0] sc, input logic [1:0] md,
                           input logic bh, input logic bm);
    check({tag, "/hour"}, hour_bcd, hr);
    check({tag, "/min"}, min_bcd, mn);
    check({tag, "/sec"}, sec_bcd, sc);
    check({tag, "/mode"}, {6'd0, mode}, {6'd0, md});
    check({tag, "/blank_hr"}, {7'd0, blank_hr}, {7'd0, bh});
    check({tag, "/blank_min"}, {7'd0, blank_min}, {7'd0, bm});
  endtask

  task automatic check_model(input string tag);
    check_all(tag, to_bcd(m_t / 3600), to_bcd((m_t / 60) % 60), to_bcd(m_t % 60),
              2'(m_md), (m_md == 1) && m_ph, (m_md == 2) && m_ph);
  endtask

  // All driving tasks start and end just after a falling edge.
  task automatic khz_tick();
    tick_1KHz = 1'b1;
    @(negedge CP);
    tick_1KHz = 1'b0;
    @(negedge CP);
  endtask

  task automatic hz_tick();
    tick_1Hz = 1'b1;
    @(negedge CP);
    tick_1Hz = 1'b0;
    @(negedge CP);
  endtask

  // Hold buttons for nt ms, optionally landing tick_1Hz on the press cycle,
  // then release and let the debounced level fall back.
  task automatic press(input logic m, input logic a, input int unsigned nt, input logic hz);
    btn_mode = m;
    btn_adj  = a;
    repeat (3) @(negedge CP);
    repeat (nt) khz_tick();
    tick_1Hz = hz;
    @(negedge CP);
    tick_1Hz = 1'b0;
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    repeat (3) @(negedge CP);
    repeat (DEB) khz_tick();
    repeat (2) @(negedge CP);
  endtask

  task automatic apply_op(input op_e op, input int unsigned n);
    case (op)
      OP_TICK:   repeat (n) begin hz_tick(); m_tick(); end
      OP_MODE:   begin press(1'b1, 1'b0, DEB, 1'b0); m_mode(); end
      OP_ADJ:    repeat (n) begin press(1'b0, 1'b1, DEB, 1'b0); m_adj(); end
      OP_BOTH:   begin press(1'b1, 1'b1, DEB, 1'b0); m_mode(); end
      OP_MODE_T: begin press(1'b1, 1'b0, DEB, 1'b1); m_tick(); m_mode(); end
      OP_ADJ_T:  begin press(1'b0, 1'b1, DEB, 1'b1); m_adj(); m_tick(); end
      OP_SHORT:  press(1'b1, 1'b0, DEB - 1, 1'b0);
      default:   ;
    endcase
  endtask

  task automatic do_reset();
    cr_n = 1'b0;
    tick_1Hz = 1'b0; tick_1KHz = 1'b0; btn_mode = 1'b0; btn_adj = 1'b0;
    repeat (3) @(negedge CP);
    cr_n = 1'b1;
    @(negedge CP);
    m_reset();
  endtask

  initial begin
    vecs.push_back('{OP_TICK,   61, 8'h00, 8'h01, 8'h01, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{OP_SHORT,   1, 8'h00, 8'h01, 8'h01, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{OP_TICK,   36, 8'h00, 8'h01, 8'h37, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{OP_MODE,    1, 8'h00, 8'h01, 8'h37, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{OP_TICK,    1, 8'h00, 8'h01, 8'h37, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{OP_TICK,    1, 8'h00, 8'h01, 8'h37, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{OP_ADJ,    23, 8'h23, 8'h01, 8'h37, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{OP_ADJ,     1, 8'h00, 8'h01, 8'h37, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{OP_ADJ,    23, 8'h23, 8'h01, 8'h37, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{OP_BOTH,    1, 8'h23, 8'h01, 8'h37, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{OP_ADJ,    58, 8'h23, 8'h59, 8'h37, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{OP_ADJ,     1, 8'h23, 8'h00, 8'h37, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{OP_ADJ,    59, 8'h23, 8'h59, 8'h37, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{OP_MODE,    1, 8'h23, 8'h59, 8'h00, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{OP_TICK,   59, 8'h23, 8'h59, 8'h59, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{OP_TICK,    1, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{OP_MODE_T,  1, 8'h00, 8'h00, 8'h01, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{OP_ADJ_T,   1, 8'h01, 8'h00, 8'h01, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{OP_MODE,    1, 8'h01, 8'h00, 8'h01, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{OP_TICK,    1, 8'h01, 8'h00, 8'h01, 2'd2, 1'b0, 1'b1});
    vecs.push_back('{OP_ADJ_T,   1, 8'h01, 8'h01, 8'h01, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{OP_MODE,    1, 8'h01, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{OP_ADJ,     1, 8'h01, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0});

    // Reset values.
    @(negedge CP);
    do_reset();
    check_all("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);

    // Press latency: pulse one cycle wide, mode visible one edge later.
    btn_mode = 1'b1;
    repeat (3) @(negedge CP);
    repeat (DEB) khz_tick();
    check("lat/pulse_high", {7'd0, dut.u_mode_db.press}, 8'd1);
    check("lat/mode_before", {6'd0, mode}, 8'd0);
    @(negedge CP);
    check("lat/pulse_low", {7'd0, dut.u_mode_db.press}, 8'd0);
    check("lat/mode_after", {6'd0, mode}, 8'd1);
    check("lat/blank_hr", {7'd0, blank_hr}, 8'd0);
    btn_mode = 1'b0;
    repeat (3) @(negedge CP);
    repeat (DEB) khz_tick();
    repeat (2) @(negedge CP);

    // Directed table.
    do_reset();
    for (int unsigned i = 0; i < vecs.size(); i++) begin
      apply_op(vecs[i].op, vecs[i].n);
      check_all($sformatf("vec%0d", i), vecs[i].hr, vecs[i].mn, vecs[i].sc,
                vecs[i].md, vecs[i].bh, vecs[i].bm);
    end

    // Random operations against the model.
    for (int unsigned i = 0; i < 150; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: apply_op(OP_TICK, $urandom_range(1, 90));
        3:       apply_op(OP_MODE, 1);
        4, 5:    apply_op(OP_ADJ, $urandom_range(1, 3));
        6:       apply_op(OP_BOTH, 1);
        7:       apply_op(OP_MODE_T, 1);
        8:       apply_op(OP_ADJ_T, 1);
        default: apply_op(OP_SHORT, 1);
      endcase
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of SET_MIN.
    repeat (2) if (m_md != 0) apply_op(OP_MODE, 1);
    apply_op(OP_TICK, 13);
    apply_op(OP_MODE, 1);
    apply_op(OP_MODE, 1);
    apply_op(OP_ADJ, 2);
    apply_op(OP_TICK, 1);
    check_model("pre_reset");
    #2 cr_n = 1'b0;
    #1 check_all("async_reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
    @(negedge CP);
    cr_n = 1'b1;
    m_reset();
    @(negedge CP);
    apply_op(OP_ADJ, 1);
    apply_op(OP_TICK, 2);
    check_model("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Timekeeping and time-set controller for the digital clock.
- Consumes the single-cycle 1Hz and 1KHz tick pulses from the clock divider.
- Maintains hours/minutes/seconds in BCD and sequences the time-set mode from two push-buttons.
- Drives the display path with BCD values plus per-field blink blanking.

Parameters:
- DEB_MS, 20, consecutive stable 1KHz samples required to accept a button level change (range 2..255).
- HOUR_MAX, 23, last hour value before wrapping to 00 (23 for a 24h clock).

Ports:
- CP  input  1  system clock, 100MHz.
- _CR  input  1  asynchronous active-low reset.
- tick_1Hz  input  1  one-CP-cycle pulse, once per second.
- tick_1KHz  input  1  one-CP-cycle pulse, once per millisecond.
- btn_mode  input  1  raw mode button, active-high, asynchronous to CP.
- btn_adj  input  1  raw adjust button, active-high, asynchronous to CP.
- hour_bcd  output  8  hours, [7:4] tens, [3:0] units.
- min_bcd  output  8  minutes, BCD.
- sec_bcd  output  8  seconds, BCD.
- mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN.
- blank_hr  output  1  display must blank the hour digits while high.
- blank_min  output  1  display must blank the minute digits while high.

Behaviour:
- Reset (_CR low, asynchronous):
  - time 00:00:00, mode RUN, blink phase 0, blank_hr and blank_min 0.
  - Debouncer shift registers, debounced levels and press pulses cleared.
  - Reset mid-operation aborts any set sequence.
- Button synchronisation: each raw button passes through a 2-flop synchroniser on CP.
- Debounce:
  - The synchronised level is sampled only on cycles where tick_1KHz=1.
  - The debounced level changes only after DEB_MS consecutive equal samples.
  - A 0->1 transition of the debounced level produces a press pulse exactly one CP cycle wide, one cycle after the level change.
- FSM, advanced by mode press:
  - RUN -> SET_HR -> SET_MIN -> RUN.
  - The 2-bit encoding value 3 is illegal; if reached, it returns to RUN on the next cycle.
- RUN:
  - On tick_1Hz, seconds increment: 59->00 carries into minutes; minutes 59->00 carries into hours; HOUR_MAX->00.
  - All fields are stored as BCD: units 9->0 with tens+1, no binary conversion.
  - Adjust presses are ignored.
- SET_HR / SET_MIN:
  - Seconds are frozen and tick_1Hz does not advance time.
  - An adjust press increments the selected field by 1 with wrap (hours HOUR_MAX->00, minutes 59->00), with no carry into other fields.
- Leaving SET_MIN to RUN clears seconds to 00 on the same edge as the state change.
- Blink:
  - The blink phase toggles on each tick_1Hz while in SET_HR or SET_MIN.
  - The phase is forced to 0 on every state change and held at 0 in RUN.
  - blank_hr = (mode==SET_HR) & phase; blank_min = (mode==SET_MIN) & phase.
  - A field is therefore always visible immediately on entering its set state.
- Simultaneous events:
  - Mode press and adjust press in the same cycle: mode press wins and the adjust press is discarded.
  - tick_1Hz and mode press in the same cycle while in RUN: the second advances and the state changes, both on that edge.
  - tick_1Hz and adjust press in the same cycle while in a set state: the field increments and the blink phase toggles.
- Latency and output timing:
  - All outputs are registered.
  - A field or mode update is visible on the CP edge after the press pulse.
  - A time update is visible on the edge after tick_1Hz.

Decomposition:
- Shared package clock_pkg:
  - mode encoding constants MODE_RUN=2'd0, MODE_SET_HR=2'd1, MODE_SET_MIN=2'd2.
  - BCD limit constants SEC_MAX=8'h59, MIN_MAX=8'h59.
  - A BCD-increment-with-wrap function (8-bit BCD in, limit in, 8-bit BCD out plus carry).
- One sub-module, btn_debounce, instantiated twice.
  - Parameter DEB_MS.
  - Ports CP, _CR, tick_1KHz, btn_raw; output press (pulse).
  - Contains the synchroniser, sample counter and edge detector.

Test Plan:
1. Reset, then 61 tick_1Hz pulses in RUN -> sec_bcd=8'h01, min_bcd=8'h01, hour_bcd=8'h00, blank_hr=blank_min=0.
2. Time preloaded by presses to 23:59:59 (HOUR_MAX=23), then one tick_1Hz -> 00:00:00 on the next edge.
3. DEB_MS=4; btn_mode held high for 3 ms, then low -> no press, mode stays 0. Held high for 4 ms -> mode=1 one edge after the press pulse, blank_hr=0.
4. In SET_HR at hour 8'h23, one adjust press -> hour_bcd=8'h00 and min_bcd unchanged. In SET_MIN at 8'h59, one adjust press -> min_bcd=8'h00 and hour unchanged.
5. In SET_MIN with sec_bcd=8'h37, mode press -> mode=0 and sec_bcd=8'h00 on the same edge. In SET_HR, two tick_1Hz pulses -> blank_hr goes 1 then 0 while seconds stay frozen.
6. Mode and adjust press pulses forced in the same cycle in SET_HR -> mode=2 and hour unchanged. _CR pulsed low mid-SET_MIN -> all outputs return to reset values immediately.
